// File: rtl/sram_access_ctrl.sv
`timescale 1ns/1ps
// sram_access_ctrl: sequences bitline precharge, wordline + write driver / sense amp, then response for one SRAM row access at a time.
// Latency: read PRE_CYCLES+WL_CYCLES+2, write PRE_CYCLES+WL_CYCLES+1, forwarded read 1 cycle(s) after the acceptance edge.
// Backpressure: req_ready only in IDLE; responses cannot be stalled, rsp_valid is a one-cycle pulse.
// Optional feature macro SRAM_CTRL_FWD_EN: a read that hits the last completed write returns its data without touching the array.
module sram_access_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] dec_addr,
    output logic                  dec_enable,
    output logic                  bl_precharge,
    output logic                  wdrv_en,
    output logic [DATA_WIDTH-1:0] wdrv_data,
    output logic                  sae,
    input  logic [DATA_WIDTH-1:0] arr_rdata
);
    // Phase counter holds (phase length - 1) and counts down to zero.
    localparam int CNT_MAX = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ACT   = 3'd2,
        S_SENSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_we_q, op_we_d;
    logic [ADDR_WIDTH-1:0] dec_addr_q, dec_addr_d;
    logic [DATA_WIDTH-1:0] wdrv_data_q, wdrv_data_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  req_ready_q, bl_precharge_q, dec_enable_q;
    logic                  wdrv_en_q, sae_q, rsp_valid_q;

    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_rdata;

`ifdef SRAM_CTRL_FWD_EN
    logic                  fwd_vld_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    assign fwd_hit   = fwd_vld_q & ~req_we & (req_addr == fwd_addr_q);
    assign fwd_rdata = fwd_data_q;

    // Remember the most recent completed write for read-after-write forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else if (state_q == S_DONE && op_we_q) begin
            fwd_vld_q  <= 1'b1;
            fwd_addr_q <= dec_addr_q;
            fwd_data_q <= wdrv_data_q;
        end
    end
`else
    assign fwd_hit   = 1'b0;
    assign fwd_rdata = '0;
`endif

    // Next-state, phase counter and request/response latches.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        dec_addr_d  = dec_addr_q;
        wdrv_data_d = wdrv_data_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_we_d     = req_we;
                    dec_addr_d  = req_addr;
                    wdrv_data_d = req_wdata;
                    if (fwd_hit) begin
                        state_d     = S_DONE;
                        cnt_d       = '0;
                        rsp_rdata_d = fwd_rdata;
                    end else begin
                        state_d = S_PRE;
                        cnt_d   = PRE_LOAD;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_ACT;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    state_d = op_we_q ? S_DONE : S_SENSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SENSE: begin
                state_d     = S_DONE;
                cnt_d       = '0;
                rsp_rdata_d = arr_rdata;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and data registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            dec_addr_q  <= '0;
            wdrv_data_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            dec_addr_q  <= dec_addr_d;
            wdrv_data_q <= wdrv_data_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Strobes are flops decoded from the next state so they track the state glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q    <= 1'b1;
            bl_precharge_q <= 1'b1;
            dec_enable_q   <= 1'b0;
            wdrv_en_q      <= 1'b0;
            sae_q          <= 1'b0;
            rsp_valid_q    <= 1'b0;
        end else begin
            req_ready_q    <= (state_d == S_IDLE);
            bl_precharge_q <= (state_d == S_IDLE) || (state_d == S_PRE) || (state_d == S_DONE);
            dec_enable_q   <= (state_d == S_ACT) || (state_d == S_SENSE);
            wdrv_en_q      <= (state_d == S_ACT) && op_we_d;
            sae_q          <= (state_d == S_SENSE);
            rsp_valid_q    <= (state_d == S_DONE);
        end
    end

    assign req_ready    = req_ready_q;
    assign bl_precharge = bl_precharge_q;
    assign dec_enable   = dec_enable_q;
    assign wdrv_en      = wdrv_en_q;
    assign sae          = sae_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign dec_addr     = dec_addr_q;
    assign wdrv_data    = wdrv_data_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
`timescale 1ns/1ps
// Bench for sram_access_ctrl: two instances (default timing and PRE=3/WL=1) checked every cycle
// against a timeline model (cycles since acceptance -> phase), plus literal expectations for
// the directed read, write, busy, mid-access reset and forwarding scenarios.
module tb_sram_access_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int P0 = 1, W0 = 2, P1 = 3, W1 = 1;
`ifdef SRAM_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [DW-1:0] arr_rdata [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_rdata [2];
    logic [AW-1:0] dec_addr  [2];
    logic          dec_enable[2];
    logic          bl_precharge[2];
    logic          wdrv_en   [2];
    logic [DW-1:0] wdrv_data [2];
    logic          sae       [2];

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;
    bit rand_arr = 1'b0;
    logic [DW-1:0] arr_fix [2] = '{8'h00, 8'h00};

    sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_CYCLES(P0), .WL_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .dec_addr(dec_addr[0]), .dec_enable(dec_enable[0]), .bl_precharge(bl_precharge[0]),
        .wdrv_en(wdrv_en[0]), .wdrv_data(wdrv_data[0]), .sae(sae[0]), .arr_rdata(arr_rdata[0])
    );

    sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_CYCLES(P1), .WL_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .dec_addr(dec_addr[1]), .dec_enable(dec_enable[1]), .bl_precharge(bl_precharge[1]),
        .wdrv_en(wdrv_en[1]), .wdrv_data(wdrv_data[1]), .sae(sae[1]), .arr_rdata(arr_rdata[1])
    );

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
        end
    endfunction

    function automatic int pof(int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int wof(int i);
        return (i == 0) ? W0 : W1;
    endfunction

    // ---------------- behavioural model ----------------
    // mk = cycles elapsed since acceptance (0 = idle); the phase follows from plain arithmetic.
    int            mk   [2] = '{0, 0};
    bit            mwe  [2] = '{1'b0, 1'b0};
    bit            mhit [2] = '{1'b0, 1'b0};
    logic [AW-1:0] maddr[2] = '{6'h0, 6'h0};
    logic [DW-1:0] mdata[2] = '{8'h0, 8'h0};
    logic [DW-1:0] mrd  [2] = '{8'h0, 8'h0};
    bit            fv   [2] = '{1'b0, 1'b0};
    logic [AW-1:0] fa   [2] = '{6'h0, 6'h0};
    logic [DW-1:0] fd   [2] = '{8'h0, 8'h0};

    function automatic int total_of(int i);
        if (mhit[i]) return 1;
        return pof(i) + wof(i) + (mwe[i] ? 1 : 2);
    endfunction

    // Returns {ready, precharge, dec_enable, wdrv_en, sae, rsp_valid}.
    function automatic logic [5:0] exp_strobes(int i);
        int k, p, w;
        k = mk[i]; p = pof(i); w = wof(i);
        if (k == 0) return 6'b110000;
        if (k == total_of(i)) return 6'b010001;
        if (k <= p) return 6'b010000;
        if (k <= p + w) return {3'b001, mwe[i], 2'b00};
        return 6'b001010;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mk[i] <= 0; mwe[i] <= 1'b0; mhit[i] <= 1'b0;
                maddr[i] <= '0; mdata[i] <= '0; mrd[i] <= '0;
                fv[i] <= 1'b0; fa[i] <= '0; fd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mk[i] == 0) begin
                    if (req_valid[i]) begin
                        mk[i]    <= 1;
                        mwe[i]   <= req_we[i];
                        maddr[i] <= req_addr[i];
                        mdata[i] <= req_wdata[i];
                        mhit[i]  <= FWD && fv[i] && !req_we[i] && (req_addr[i] == fa[i]);
                        if (FWD && fv[i] && !req_we[i] && (req_addr[i] == fa[i]))
                            mrd[i] <= fd[i];
                    end
                end else begin
                    if (!mwe[i] && !mhit[i] && mk[i] == pof(i) + wof(i) + 1)
                        mrd[i] <= arr_rdata[i];
                    if (mk[i] == total_of(i)) begin
                        mk[i] <= 0;
                        if (mwe[i]) begin
                            fv[i] <= 1'b1;
                            fa[i] <= maddr[i];
                            fd[i] <= mdata[i];
                        end
                    end else begin
                        mk[i] <= mk[i] + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("req_ready",    i, 32'(req_ready[i]),    32'(exp_strobes(i) >> 5) & 32'd1);
                chk("bl_precharge", i, 32'(bl_precharge[i]), 32'(exp_strobes(i) >> 4) & 32'd1);
                chk("dec_enable",   i, 32'(dec_enable[i]),   32'(exp_strobes(i) >> 3) & 32'd1);
                chk("wdrv_en",      i, 32'(wdrv_en[i]),      32'(exp_strobes(i) >> 2) & 32'd1);
                chk("sae",          i, 32'(sae[i]),          32'(exp_strobes(i) >> 1) & 32'd1);
                chk("rsp_valid",    i, 32'(rsp_valid[i]),    32'(exp_strobes(i)) & 32'd1);
                chk("rsp_rdata",    i, 32'(rsp_rdata[i]),    32'(mrd[i]));
                chk("dec_addr",     i, 32'(dec_addr[i]),     32'(maddr[i]));
                chk("wdrv_data",    i, 32'(wdrv_data[i]),    32'(mdata[i]));
                chk("pre_dec_overlap", i, 32'(bl_precharge[i] & dec_enable[i]), 32'd0);
            end
        end
    end

    // Array read data: fixed per directed test, random during the random phase.
    initial begin
        arr_rdata[0] = '0;
        arr_rdata[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                arr_rdata[i] = rand_arr ? 8'($urandom) : arr_fix[i];
        end
    end

    // One request on instance i: waits for acceptance, then counts cycles up to the response.
    task automatic do_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output int n_dec, output int n_sae, output int n_wdrv);
        int guard;
        lat = 0; n_dec = 0; n_sae = 0; n_wdrv = 0;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
        guard = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready[i]) break;
            guard++;
            if (guard > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout dut%0d: no req_ready within 50 cycles", i);
                req_valid[i] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            n_dec  += int'(dec_enable[i]);
            n_sae  += int'(sae[i]);
            n_wdrv += int'(wdrv_en[i]);
            if (rsp_valid[i]) break;
            if (lat > 50) begin
                checks++; errors++;
                $display("FAIL rsp_timeout dut%0d: no rsp_valid within 50 cycles", i);
                break;
            end
        end
    endtask

    task automatic rand_txns(input int i, input int n);
        int l, a, b, c;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_req(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom), l, a, b, c);
        end
    endtask

    initial begin
        int lat, nd, ns, nw, n;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
        end

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_bl_precharge", i, 32'(bl_precharge[i]), 32'd1);
            chk("rst_dec_enable", i, 32'(dec_enable[i]), 32'd0);
            chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_rdata", i, 32'(rsp_rdata[i]), 32'd0);
            chk("rst_dec_addr", i, 32'(dec_addr[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Read 0x2A, array returns 0xA5
        arr_fix[0] = 8'hA5;
        do_req(0, 1'b0, 6'h2A, 8'h00, lat, nd, ns, nw);
        chk("rd_latency", 0, lat, 5);
        chk("rd_dec_cycles", 0, nd, 3);
        chk("rd_sae_cycles", 0, ns, 1);
        chk("rd_wdrv_cycles", 0, nw, 0);
        chk("rd_rdata", 0, 32'(rsp_rdata[0]), 32'hA5);
        chk("rd_dec_addr", 0, 32'(dec_addr[0]), 32'h2A);

        // Write 0x3F = 0x5C; array output changed so a stray capture would show
        arr_fix[0] = 8'h3C;
        do_req(0, 1'b1, 6'h3F, 8'h5C, lat, nd, ns, nw);
        chk("wr_latency", 0, lat, 4);
        chk("wr_wdrv_cycles", 0, nw, 2);
        chk("wr_sae_cycles", 0, ns, 0);
        chk("wr_wdrv_data", 0, 32'(wdrv_data[0]), 32'h5C);
        chk("wr_rdata_kept", 0, 32'(rsp_rdata[0]), 32'hA5);

`ifdef SRAM_CTRL_FWD_EN
        do_req(0, 1'b1, 6'h11, 8'h77, lat, nd, ns, nw);
        arr_fix[0] = 8'h99;
        do_req(0, 1'b0, 6'h11, 8'h00, lat, nd, ns, nw);
        chk("fwd_latency", 0, lat, 1);
        chk("fwd_rdata", 0, 32'(rsp_rdata[0]), 32'h77);
        chk("fwd_dec_cycles", 0, nd, 0);
        do_req(0, 1'b0, 6'h12, 8'h00, lat, nd, ns, nw);
        chk("nofwd_latency", 0, lat, 5);
        chk("nofwd_rdata", 0, 32'(rsp_rdata[0]), 32'h99);
`endif

        // Busy handling on the PRE=3/WL=1 instance: request held through the whole access
        arr_fix[1] = 8'h42;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 6'h05; req_wdata[1] = 8'h00;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
        @(posedge clk);
        #1;
        req_addr[1] = 6'h06;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
        chk("busy_ready_gap", 1, n, 7);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 50);
        chk("busy_second_latency", 1, n, 6);
        chk("busy_second_addr", 1, 32'(dec_addr[1]), 32'h06);
        chk("busy_rdata", 1, 32'(rsp_rdata[1]), 32'h42);

        // Mid-access reset during ACT
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 6'h07;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dec_enable[0] && n < 50);
        chk("arst_reached_act", 0, 32'(dec_enable[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_dec_enable", 0, 32'(dec_enable[0]), 32'd0);
        chk("arst_bl_precharge", 0, 32'(bl_precharge[0]), 32'd1);
        chk("arst_req_ready", 0, 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin @(negedge clk); n += int'(rsp_valid[0]); end
        chk("arst_no_rsp", 0, n, 0);
        arr_fix[0] = 8'h6B;
        do_req(0, 1'b0, 6'h2A, 8'h00, lat, nd, ns, nw);
        chk("arst_next_latency", 0, lat, 5);
        chk("arst_next_rdata", 0, 32'(rsp_rdata[0]), 32'h6B);

        // Random traffic on both instances, checked by the per-cycle model
        rand_arr = 1'b1;
        fork
            rand_txns(0, 40);
            rand_txns(1, 40);
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        cmp_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
